fft64_twiddle_mult_blk: RTL and testbench

Four-lane pipelined twiddle-factor multiplier for the 64-point FFT datapath. It sits directly downstream of the four reordering FIFO blocks, which use read offsets 0/4/8/12. Each lane takes one complex sample per cycle and multiplies it by W64^(lane*k), where k is the sample's position within a 16-cycle frame. Frame alignment comes from the same single-cycle ctrl pulse used by the FIFOs, and the block forwards that pulse, delayed, to the next butterfly stage.

---
 rtl/fft64_twiddle_mult_blk.sv | 188 ++++++++++++++++++
 tb/tb_fft64_twiddle_mult_blk.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft64_twiddle_mult_blk.sv
// Four-lane pipelined twiddle multiplier for the 64-point FFT: lane n multiplies
// its sample by W64^((LANE_BASE+n)*k) with a 3-cycle registered datapath.
module fft64_twiddle_mult_blk #(
    parameter int unsigned LANE_BASE = 0,
    parameter int unsigned LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in_0,
    input  logic [31:0] data_in_1,
    input  logic [31:0] data_in_2,
    input  logic [31:0] data_in_3,
    input  logic        ctrl_in,
    output logic [31:0] data_out_0,
    output logic [31:0] data_out_1,
    output logic [31:0] data_out_2,
    output logic [31:0] data_out_3,
    output logic        ctrl_out,
    output logic [3:0]  k_idx,
    output logic        busy
);

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 32;
    localparam int unsigned SW    = 33;
    localparam int unsigned KW    = 4;
    localparam int unsigned EW    = 6;

    localparam logic signed [SW-1:0] RND     = 33'sd16384;
    localparam logic signed [SW-1:0] SAT_MAX = 33'sd32767;
    localparam logic signed [SW-1:0] SAT_MIN = -33'sd32768;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nx;
    logic [KW-1:0] cnt, cnt_nx;

    // Quarter-wave cosine table: round(32767*cos(2*pi*i/64)), i = 0..16
    function automatic logic [DW-1:0] qcos(input logic [4:0] i);
        case (i)
            5'd0:    return 16'd32767;
            5'd1:    return 16'd32609;
            5'd2:    return 16'd32137;
            5'd3:    return 16'd31356;
            5'd4:    return 16'd30273;
            5'd5:    return 16'd28898;
            5'd6:    return 16'd27245;
            5'd7:    return 16'd25329;
            5'd8:    return 16'd23170;
            5'd9:    return 16'd20787;
            5'd10:   return 16'd18204;
            5'd11:   return 16'd15446;
            5'd12:   return 16'd12539;
            5'd13:   return 16'd9512;
            5'd14:   return 16'd6393;
            5'd15:   return 16'd3212;
            default: return 16'd0;
        endcase
    endfunction

    // {cos, -sin} of 2*pi*e/64 folded from the quarter table by quadrant
    function automatic logic [CW-1:0] twiddle(input logic [EW-1:0] e);
        logic [4:0]    ri;
        logic [DW-1:0] cv;
        logic [DW-1:0] sv;
        ri = {1'b0, e[3:0]};
        cv = qcos(ri);
        sv = qcos(5'd16 - ri);
        case (e[5:4])
            2'd0:    return {cv, -sv};
            2'd1:    return {-sv, -cv};
            2'd2:    return {-cv, sv};
            default: return {sv, cv};
        endcase
    endfunction

    function automatic logic signed [CW-1:0] sx(input logic [DW-1:0] v);
        return {{DW{v[DW-1]}}, v};
    endfunction

    function automatic logic [DW-1:0] rnd_sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
        r = (s + RND) >>> 15;
        if (r > SAT_MAX)      return 16'h7FFF;
        else if (r < SAT_MIN) return 16'h8000;
        else                  return r[DW-1:0];
    endfunction

    // Frame position state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (ctrl_in) begin
            state_nx = RUN;
            cnt_nx   = KW'(1);
        end else if (state == RUN) begin
            if (cnt == KW'(15)) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + KW'(1);
            end
        end
    end

    // ctrl_in marks k=0 of the current input-stage sample
    always_comb begin
        busy  = ctrl_in || (state == RUN);
        k_idx = ctrl_in ? '0 : cnt;
    end

    logic [CW-1:0]        din  [LANES];
    logic [CW-1:0]        dout [LANES];
    logic [EW-1:0]        e_c  [LANES];
    logic [CW-1:0]        tw_c [LANES];
    logic [CW-1:0]        d1   [LANES];
    logic [EW-1:0]        e1   [LANES];
    logic [CW-1:0]        d2   [LANES];
    logic signed [CW-1:0] p_ac [LANES];
    logic signed [CW-1:0] p_bd [LANES];
    logic signed [CW-1:0] p_ad [LANES];
    logic signed [CW-1:0] p_bc [LANES];
    logic [LANES-1:0]     byp1, byp2;
    logic [LATENCY-1:0]   ctrl_sr;

    assign din[0]     = data_in_0;
    assign din[1]     = data_in_1;
    assign din[2]     = data_in_2;
    assign din[3]     = data_in_3;
    assign data_out_0 = dout[0];
    assign data_out_1 = dout[1];
    assign data_out_2 = dout[2];
    assign data_out_3 = dout[3];
    assign ctrl_out   = ctrl_sr[LATENCY-1];

    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            e_c[n]  = busy ? EW'(EW'(LANE_BASE + 32'(n)) * {2'b00, k_idx}) : '0;
            tw_c[n] = twiddle(e1[n]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_sr <= '0;
            byp1    <= '0;
            byp2    <= '0;
            for (int n = 0; n < LANES; n++) begin
                d1[n]   <= '0;
                e1[n]   <= '0;
                d2[n]   <= '0;
                p_ac[n] <= '0;
                p_bd[n] <= '0;
                p_ad[n] <= '0;
                p_bc[n] <= '0;
                dout[n] <= '0;
            end
        end else begin
            ctrl_sr <= {ctrl_sr[LATENCY-2:0], ctrl_in};
            byp2    <= byp1;
            for (int n = 0; n < LANES; n++) begin
                d1[n]   <= din[n];
                e1[n]   <= e_c[n];
                byp1[n] <= (e_c[n] == '0);
                d2[n]   <= d1[n];
                p_ac[n] <= sx(d1[n][31:16]) * sx(tw_c[n][31:16]);
                p_bd[n] <= sx(d1[n][15:0])  * sx(tw_c[n][15:0]);
                p_ad[n] <= sx(d1[n][31:16]) * sx(tw_c[n][15:0]);
                p_bc[n] <= sx(d1[n][15:0])  * sx(tw_c[n][31:16]);
                dout[n] <= byp2[n] ? d2[n] :
                           {rnd_sat({p_ac[n][CW-1], p_ac[n]} - {p_bd[n][CW-1], p_bd[n]}),
                            rnd_sat({p_ad[n][CW-1], p_ad[n]} + {p_bc[n][CW-1], p_bc[n]})};
            end
        end
    end

endmodule

// File: tb/tb_fft64_twiddle_mult_blk.sv
// Scoreboard bench for fft64_twiddle_mult_blk: a trigonometric reference model
// predicts each lane output; a negedge monitor compares them LATENCY cycles later.
module tb_fft64_twiddle_mult_blk;

    localparam int LANE_BASE = 0;
    localparam int LAT       = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_in_0 = '0, data_in_1 = '0, data_in_2 = '0, data_in_3 = '0;
    logic        ctrl_in = 1'b0;
    logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3;
    logic        ctrl_out;
    logic [3:0]  k_idx;
    logic        busy;

    always #5 clk = ~clk;

    fft64_twiddle_mult_blk #(.LANE_BASE(LANE_BASE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .data_in_0(data_in_0), .data_in_1(data_in_1),
        .data_in_2(data_in_2), .data_in_3(data_in_3),
        .ctrl_in(ctrl_in),
        .data_out_0(data_out_0), .data_out_1(data_out_1),
        .data_out_2(data_out_2), .data_out_3(data_out_3),
        .ctrl_out(ctrl_out), .k_idx(k_idx), .busy(busy)
    );

    typedef struct {
        int               tag;
        logic [3:0][31:0] d;
        logic             ctrl;
    } exp_t;

    typedef struct {
        int          tag;
        int          lane;
        logic [31:0] val;
        string       name;
    } dir_t;

    exp_t sb[$];
    dir_t dq[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_edge   = 0;
    int   last_tag = 0;
    int   mk       = 0;
    bit   mbusy    = 1'b0;

    always @(posedge clk) n_edge <= n_edge + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        else          return -$rtoi($floor(-x + 0.5));
    endfunction

    function automatic logic [15:0] satr(input longint v);
        if (v > 32767)       return 16'h7FFF;
        else if (v < -32768) return 16'h8000;
        else                 return 16'(v);
    endfunction

    function automatic logic [31:0] twmul(input logic [31:0] x, input int e);
        real    th;
        longint a, b, c, d, re, im;
        if (e == 0) return x;
        th = 2.0 * 3.14159265358979323846 * real'(e) / 64.0;
        c  = longint'(rnd(32767.0 * $cos(th)));
        d  = longint'(rnd(-32767.0 * $sin(th)));
        a  = longint'($signed(x[31:16]));
        b  = longint'($signed(x[15:0]));
        re = a * c - b * d;
        im = a * d + b * c;
        return {satr((re + 16384) >>> 15), satr((im + 16384) >>> 15)};
    endfunction

    function automatic logic [3:0][31:0] rnd_vec();
        logic [3:0][31:0] v;
        for (int i = 0; i < 4; i++) v[i] = $urandom;
        return v;
    endfunction

    task automatic step(input bit c, input logic [3:0][31:0] v);
        exp_t ex;
        int   k;
        bit   b;
        @(posedge clk);
        #1;
        ctrl_in   = c;
        data_in_0 = v[0];
        data_in_1 = v[1];
        data_in_2 = v[2];
        data_in_3 = v[3];
        if (c)          begin k = 0;  b = 1'b1; end
        else if (mbusy) begin k = mk; b = 1'b1; end
        else            begin k = 0;  b = 1'b0; end
        ex.tag  = n_edge + 1;
        ex.ctrl = c;
        for (int i = 0; i < 4; i++)
            ex.d[i] = twmul(v[i], b ? ((LANE_BASE + i) * k) % 64 : 0);
        sb.push_back(ex);
        last_tag = ex.tag;
        if (b && k < 15) begin mbusy = 1'b1; mk = k + 1; end
        else             begin mbusy = 1'b0; mk = 0;     end
        #1;
        chk("k_idx", 32'(k_idx), 32'(k));
        chk("busy", 32'(busy), 32'(b));
    endtask

    task automatic do_reset(input int cyc);
        ctrl_in   = 1'b0;
        data_in_0 = '0;
        data_in_1 = '0;
        data_in_2 = '0;
        data_in_3 = '0;
        rst       = 1'b1;
        sb.delete();
        dq.delete();
        mk    = 0;
        mbusy = 1'b0;
        #1;
        chk("rst_out0", data_out_0, 32'h0);
        chk("rst_out1", data_out_1, 32'h0);
        chk("rst_out2", data_out_2, 32'h0);
        chk("rst_out3", data_out_3, 32'h0);
        chk("rst_ctrl_out", 32'(ctrl_out), 32'h0);
        chk("rst_k_idx", 32'(k_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        repeat (cyc) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Monitor: pop the entry whose output edge has just occurred
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].tag + 2 < n_edge) begin
                failures++;
                $display("FAIL sb_stale: entry tag %0d unmatched at edge %0d", sb[0].tag, n_edge);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].tag + 2 == n_edge) begin
                exp_t ex;
                ex = sb.pop_front();
                chk("lane0", data_out_0, ex.d[0]);
                chk("lane1", data_out_1, ex.d[1]);
                chk("lane2", data_out_2, ex.d[2]);
                chk("lane3", data_out_3, ex.d[3]);
                chk("ctrl_out", 32'(ctrl_out), 32'(ex.ctrl));
            end
            while (dq.size() > 0 && dq[0].tag + 2 <= n_edge) begin
                dir_t dd;
                logic [31:0] act;
                dd = dq.pop_front();
                case (dd.lane)
                    0:       act = data_out_0;
                    1:       act = data_out_1;
                    2:       act = data_out_2;
                    default: act = data_out_3;
                endcase
                if (dd.tag + 2 == n_edge) chk(dd.name, act, dd.val);
                else begin
                    failures++;
                    $display("FAIL %s: directed entry missed at edge %0d", dd.name, n_edge);
                end
            end
        end
    end

    initial begin
        logic [3:0][31:0] v;
        int               w;

        do_reset(10);

        // Frame 1: lane 0 ramp, quarter turn on lane 2, 45 degrees on lane 1
        for (int k = 0; k < 16; k++) begin
            v = rnd_vec();
            v[0][31:16] = 16'(4 * k + 1);
            if (k == 8) begin
                v[1] = {16'd10000, 16'd0};
                v[2] = {16'd16384, 16'd0};
            end
            step(k == 0, v);
            if (k == 8) begin
                dq.push_back('{last_tag, 1, {16'd7071, 16'hE461}, "rot45"});
                dq.push_back('{last_tag, 2, {16'd0, 16'hC001}, "quarter_turn"});
            end
        end

        // Frame 2 back-to-back, with a saturating sample on lane 1
        for (int k = 0; k < 16; k++) begin
            v = rnd_vec();
            if (k == 8) v[1] = {16'h8000, 16'h8000};
            step(k == 0, v);
            if (k == 8) dq.push_back('{last_tag, 1, {16'h8000, 16'h0000}, "saturate"});
        end

        // Idle: every lane bypassed
        for (int i = 0; i < 7; i++) begin
            v = rnd_vec();
            step(1'b0, v);
            if (i == 4) dq.push_back('{last_tag, 3, v[3], "idle_bypass"});
        end

        // Restart at k=10
        for (int j = 0; j < 26; j++) step(j == 0 || j == 10, rnd_vec());
        for (int j = 0; j < 4; j++)  step(1'b0, rnd_vec());

        // Random frame pulses
        for (int j = 0; j < 300; j++) step($urandom_range(0, 19) == 0, rnd_vec());

        // Mid-frame reset, idle, then a clean frame
        for (int j = 0; j < 7; j++) step(j == 0, rnd_vec());
        #2;
        do_reset(3);
        for (int j = 0; j < 6; j++)  step(1'b0, rnd_vec());
        for (int k = 0; k < 16; k++) step(k == 0, rnd_vec());
        for (int j = 0; j < 4; j++)  step(1'b0, rnd_vec());

        w = 0;
        while ((sb.size() > 0 || dq.size() > 0) && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0 || dq.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d scoreboard entries left, required 0", sb.size() + dq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
